// File: rtl/exe_pkg.sv
// Shared constants for the iterative execute unit: opcodes, shift types,
// flag bit positions and the sequencing FSM states.
package exe_pkg;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU with {N,Z,C,V} generation. Subtraction is done as
// rn + ~op2 + cin so the carry out is directly the NOT-borrow flag.
module exe_alu
  import exe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   exe_cmd,
  input  logic [W-1:0] rn,
  input  logic [W-1:0] op2,
  input  logic [3:0]   sr_in,
  output logic [W-1:0] result,
  output logic [3:0]   status
);

  logic [W:0]   sum;
  logic [W-1:0] b;
  logic         cin;
  logic         arith;

  always_comb begin
    result = '0;
    b      = op2;
    cin    = 1'b0;
    arith  = 1'b0;
    case (exe_cmd)
      OP_MOV: result = op2;
      OP_MVN: result = ~op2;
      OP_ADD: arith = 1'b1;
      OP_ADC: begin arith = 1'b1; cin = sr_in[FLAG_C]; end
      OP_SUB: begin arith = 1'b1; b = ~op2; cin = 1'b1; end
      OP_SBC: begin arith = 1'b1; b = ~op2; cin = sr_in[FLAG_C]; end
      OP_AND: result = rn & op2;
      OP_ORR: result = rn | op2;
      OP_EOR: result = rn ^ op2;
      default: result = '0;
    endcase
    sum = {1'b0, rn} + {1'b0, b} + (W+1)'(cin);
    if (arith) result = sum[W-1:0];
    status[FLAG_N] = result[W-1];
    status[FLAG_Z] = (result == '0);
    status[FLAG_C] = arith ? sum[W] : sr_in[FLAG_C];
    status[FLAG_V] = arith ? ((rn[W-1] == b[W-1]) && (result[W-1] != rn[W-1]))
                           : sr_in[FLAG_V];
  end

endmodule

// File: rtl/exe_iter_unit.sv
// Execute stage with a bit-serial barrel-shifter replacement: operand 2 is
// shifted one bit per cycle, then the ALU result is registered for handshake.
module exe_iter_unit
  import exe_pkg::*;
#(
  parameter int W      = 32,
  parameter int SIMM_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [3:0]        exe_cmd,
  input  logic              imm,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              s_bit,
  input  logic [3:0]        sr_in,
  input  logic [W-1:0]      pc,
  input  logic [W-1:0]      val_rn,
  input  logic [W-1:0]      val_rm,
  input  logic [11:0]       shift_op,
  input  logic [SIMM_W-1:0] signed_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      alu_result,
  output logic [W-1:0]      br_address,
  output logic [3:0]        status,
  output logic              status_we
);

  state_t       state, state_next;
  logic [W-1:0] op2_q, rn_q, br_q;
  logic [1:0]   sh_type_q;
  logic [4:0]   cnt_q;
  logic [3:0]   cmd_q, sr_q;
  logic         swe_q;
  logic [W-1:0] alu_res;
  logic [3:0]   alu_status;
  logic [W-1:0] simm_ext;
  logic         accept, mem_op;

  assign simm_ext  = W'($signed(signed_imm));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mem_op    = mem_read | mem_write;

  exe_alu #(.W(W)) u_alu (
    .exe_cmd (cmd_q),
    .rn      (rn_q),
    .op2     (op2_q),
    .sr_in   (sr_q),
    .result  (alu_res),
    .status  (alu_status)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_next = SHIFT;
        SHIFT:   if (cnt_q == 5'd0) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Flush only needs to kill status_we; stale datapath registers are harmless
  // because out_valid is derived from the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      op2_q      <= '0;
      rn_q       <= '0;
      br_q       <= '0;
      sh_type_q  <= SH_LSL;
      cnt_q      <= '0;
      cmd_q      <= '0;
      sr_q       <= '0;
      swe_q      <= 1'b0;
      alu_result <= '0;
      br_address <= '0;
      status     <= '0;
      status_we  <= 1'b0;
    end else if (flush) begin
      status_we <= 1'b0;
    end else if (accept) begin
      rn_q  <= val_rn;
      cmd_q <= exe_cmd;
      sr_q  <= sr_in;
      br_q  <= pc + simm_ext;
      swe_q <= s_bit & ~mem_op;
      if (mem_op) begin
        op2_q     <= W'(shift_op[11:0]);
        sh_type_q <= SH_LSL;
        cnt_q     <= 5'd0;
      end else if (imm) begin
        op2_q     <= W'(shift_op[7:0]);
        sh_type_q <= SH_ROR;
        cnt_q     <= {shift_op[11:8], 1'b0};
      end else begin
        op2_q     <= val_rm;
        sh_type_q <= shift_op[6:5];
        cnt_q     <= shift_op[11:7];
      end
    end else if (state == SHIFT) begin
      if (cnt_q != 5'd0) begin
        case (sh_type_q)
          SH_LSL:  op2_q <= {op2_q[W-2:0], 1'b0};
          SH_LSR:  op2_q <= {1'b0, op2_q[W-1:1]};
          SH_ASR:  op2_q <= {op2_q[W-1], op2_q[W-1:1]};
          default: op2_q <= {op2_q[0], op2_q[W-1:1]};
        endcase
        cnt_q <= cnt_q - 5'd1;
      end else begin
        alu_result <= alu_res;
        status     <= alu_status;
        br_address <= br_q;
        status_we  <= swe_q;
      end
    end
  end

endmodule

// File: tb/tb_exe_iter_unit.sv
// Scoreboard bench for exe_iter_unit: a driver pushes reference-model results,
// a monitor compares them (and latency) whenever out_valid is presented.
module tb_exe_iter_unit;
  import exe_pkg::*;

  localparam int W      = 32;
  localparam int SIMM_W = 24;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic              clk, rst, in_valid, in_ready, flush;
  logic [3:0]        exe_cmd;
  logic              imm, mem_read, mem_write, s_bit;
  logic [3:0]        sr_in;
  logic [W-1:0]      pc, val_rn, val_rm;
  logic [11:0]       shift_op;
  logic [SIMM_W-1:0] signed_imm;
  logic              out_valid, out_ready;
  logic [W-1:0]      alu_result, br_address;
  logic [3:0]        status;
  logic              status_we;

  exe_iter_unit #(.W(W), .SIMM_W(SIMM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .exe_cmd(exe_cmd), .imm(imm), .mem_read(mem_read), .mem_write(mem_write),
    .s_bit(s_bit), .sr_in(sr_in), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .shift_op(shift_op), .signed_imm(signed_imm), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .br_address(br_address),
    .status(status), .status_we(status_we)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic        imm, mr, mw, s;
    logic [3:0]  sr;
    logic [31:0] pc, rn, rm;
    logic [11:0] shop;
    logic [23:0] simm;
  } op_t;

  typedef struct {
    logic [31:0] res, br;
    logic [3:0]  st;
    logic        swe;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   seen = 0;
  bit   hold_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: shift by whole amount, arithmetic on wide integers.
  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [31:0] v, op2, r;
    logic [1:0] typ;
    int n;
    longint unsigned ua, ub, us;
    longint sa, sb2, ss;
    longint unsigned bor;
    logic c, cf, vf;
    if (o.mr || o.mw) begin
      v = {20'b0, o.shop}; typ = 2'd0; n = 0;
    end else if (o.imm) begin
      v = {24'b0, o.shop[7:0]}; typ = 2'd3; n = 2 * int'(o.shop[11:8]);
    end else begin
      v = o.rm; typ = o.shop[6:5]; n = int'(o.shop[11:7]);
    end
    case (typ)
      2'd0: op2 = v << n;
      2'd1: op2 = v >> n;
      2'd2: op2 = $signed(v) >>> n;
      default: op2 = (v >> n) | (v << (32 - n));
    endcase
    c   = o.sr[1];
    cf  = o.sr[1];
    vf  = o.sr[0];
    ua  = {32'b0, o.rn};
    ub  = {32'b0, op2};
    sa  = longint'($signed(o.rn));
    sb2 = longint'($signed(op2));
    r   = 32'd0;
    case (o.cmd)
      4'b0001: r = op2;
      4'b1001: r = ~op2;
      4'b0010, 4'b0011: begin
        bor = (o.cmd == 4'b0011 && c) ? 64'd1 : 64'd0;
        us  = ua + ub + bor;
        r   = us[31:0];
        cf  = us[32];
        ss  = sa + sb2 + longint'(bor);
        vf  = (ss > MAX_S) || (ss < MIN_S);
      end
      4'b0100, 4'b0101: begin
        bor = (o.cmd == 4'b0101 && !c) ? 64'd1 : 64'd0;
        r   = o.rn - op2 - bor[31:0];
        cf  = (ua >= ub + bor);
        ss  = sa - sb2 - longint'(bor);
        vf  = (ss > MAX_S) || (ss < MIN_S);
      end
      4'b0110: r = o.rn & op2;
      4'b0111: r = o.rn | op2;
      4'b1000: r = o.rn ^ op2;
      default: r = 32'd0;
    endcase
    e.res = r;
    e.st  = {r[31], (r == 32'd0), cf, vf};
    e.swe = o.s & ~(o.mr | o.mw);
    e.br  = o.pc + {{8{o.simm[23]}}, o.simm};
    e.lat = n + 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic scrambleInputs();
    exe_cmd = 4'($urandom); imm = 1'($urandom); mem_read = 1'($urandom);
    mem_write = 1'($urandom); s_bit = 1'($urandom); sr_in = 4'($urandom);
    pc = $urandom; val_rn = $urandom; val_rm = $urandom;
    shift_op = 12'($urandom); signed_imm = 24'($urandom);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic applyStimulus(input op_t o);
    exp_t e;
    int waited = 0;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
      return;
    end
    exe_cmd = o.cmd; imm = o.imm; mem_read = o.mr; mem_write = o.mw;
    s_bit = o.s; sr_in = o.sr; pc = o.pc; val_rn = o.rn; val_rm = o.rm;
    shift_op = o.shop; signed_imm = o.simm;
    in_valid = 1'b1;
    e = model(o);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    scrambleInputs();
  endtask

  task automatic waitIdle();
    int k = 0;
    while (sb.size() != 0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
      seen = 0;
    end
    @(negedge clk);
  endtask

  task automatic waitValid();
    int k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  function automatic op_t mkOp(input logic [3:0] cmd, input logic i, input logic mr,
                               input logic s, input logic [31:0] rn, input logic [31:0] rm,
                               input logic [11:0] shop);
    op_t o;
    o.cmd = cmd; o.imm = i; o.mr = mr; o.mw = 1'b0; o.s = s; o.sr = 4'b0000;
    o.pc = 32'h0; o.rn = rn; o.rm = rm; o.shop = shop; o.simm = 24'h0;
    return o;
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: samples just after each rising edge and owns out_ready.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL unexpected_out_valid: out_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb[0];
          if (!seen) begin
            checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
            seen = 1;
          end
          checkOutput("alu_result", alu_result, e.res);
          checkOutput("br_address", br_address, e.br);
          checkOutput("status", 32'(status), 32'(e.st));
          checkOutput("status_we", 32'(status_we), 32'(e.swe));
        end
      end
      out_ready = hold_ready ? 1'b0 : ($urandom_range(3) != 0);
      if (out_valid && out_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        seen = 0;
      end
    end
  end

  initial begin
    op_t o;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    scrambleInputs();
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_alu_result", alu_result, 32'd0);
    checkOutput("reset_br_address", br_address, 32'd0);
    checkOutput("reset_status", 32'(status), 32'd0);
    checkOutput("reset_status_we", 32'(status_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(mkOp(OP_MOV, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 12'h2FF));
    applyStimulus(mkOp(OP_ADD, 1'b0, 1'b0, 1'b1, 32'd5, 32'd2, 12'h180));
    applyStimulus(mkOp(OP_MOV, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 12'h240));
    applyStimulus(mkOp(OP_SUB, 1'b0, 1'b0, 1'b1, 32'd7, 32'd7, 12'h000));
    o = mkOp(OP_ADD, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 12'hABC);
    o.pc = 32'h40; o.simm = 24'hFFFFFC;
    applyStimulus(o);
    waitIdle();

    // Flush two cycles into a ten-step rotate.
    applyStimulus(mkOp(OP_ORR, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 12'h560));
    flush = 1'b1;
    void'(sb.pop_back());
    seen = 0;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_status_we", 32'(status_we), 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("flush_no_valid", 32'(out_valid), 32'd0);

    // Hold in DONE with garbage in_valid presented.
    hold_ready = 1;
    applyStimulus(mkOp(OP_EOR, 1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 32'h0000_FFFF, 12'h1A0));
    waitValid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      scrambleInputs();
      @(negedge clk);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    hold_ready = 0;
    waitIdle();

    // Reset while DONE discards the result.
    hold_ready = 1;
    applyStimulus(mkOp(OP_ADC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1, 12'h000));
    waitValid();
    rst = 1'b1;
    sb.delete();
    seen = 0;
    @(negedge clk);
    rst = 1'b0;
    hold_ready = 0;
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_alu_result", alu_result, 32'd0);
    checkOutput("rst_mid_status_we", 32'(status_we), 32'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      o.cmd  = 4'($urandom);
      o.imm  = 1'($urandom);
      o.mr   = ($urandom_range(7) == 0);
      o.mw   = !o.mr && ($urandom_range(7) == 0);
      o.s    = 1'($urandom);
      o.sr   = 4'($urandom);
      o.pc   = $urandom;
      o.rn   = pickVal();
      o.rm   = pickVal();
      o.shop = 12'($urandom);
      o.simm = 24'($urandom);
      applyStimulus(o);
    end
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
